// File: rtl/iomem_arbiter_if.sv
// ---------------------------------------------------------------------------
// iomem_arbiter_if
// Bundles the two bus-master request/response channels and the single I/O
// memory data port that the iomem_arbiter shares between them.
//
// Signals (N = 0, 1):
//   mN_req, mN_we, mN_lock   master -> arbiter  request, 1=write, keep ownership
//   mN_addr, mN_wdata        master -> arbiter  byte address, write data
//   mN_gnt                   arbiter -> master  transfer issued this cycle
//   mN_rvalid, mN_rdata      arbiter -> master  read-return pulse and data
//   mem_we, mem_addr,
//   mem_wdata                arbiter -> memory  write_enable/address/data_input
//   mem_rdata                memory -> arbiter  data_output
//
// Modports:
//   slave  - the arbiter's view
//   master - the environment's view (masters plus memory), used by benches
// ---------------------------------------------------------------------------
interface iomem_arbiter_if;
    logic        m0_req;
    logic        m0_we;
    logic        m0_lock;
    logic [31:0] m0_addr;
    logic [31:0] m0_wdata;
    logic        m0_gnt;
    logic        m0_rvalid;
    logic [31:0] m0_rdata;

    logic        m1_req;
    logic        m1_we;
    logic        m1_lock;
    logic [31:0] m1_addr;
    logic [31:0] m1_wdata;
    logic        m1_gnt;
    logic        m1_rvalid;
    logic [31:0] m1_rdata;

    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [31:0] mem_rdata;

    modport slave (
        input  m0_req, m0_we, m0_lock, m0_addr, m0_wdata,
        output m0_gnt, m0_rvalid, m0_rdata,
        input  m1_req, m1_we, m1_lock, m1_addr, m1_wdata,
        output m1_gnt, m1_rvalid, m1_rdata,
        output mem_we, mem_addr, mem_wdata,
        input  mem_rdata
    );

    modport master (
        output m0_req, m0_we, m0_lock, m0_addr, m0_wdata,
        input  m0_gnt, m0_rvalid, m0_rdata,
        output m1_req, m1_we, m1_lock, m1_addr, m1_wdata,
        input  m1_gnt, m1_rvalid, m1_rdata,
        input  mem_we, mem_addr, mem_wdata,
        output mem_rdata
    );
endinterface

// File: rtl/iomem_arbiter.sv
// ---------------------------------------------------------------------------
// iomem_arbiter
// Shares the single data port of the I/O memory subsystem between master 0
// (ARM data port) and master 1 (sprite/blitter). One single-beat transfer is
// issued per cycle, arbitrated round-robin, with an optional lock that lets
// one master keep the port for a read-modify-write sequence (bounded by
// MAX_LOCK grants). Read data is steered back to the issuing master RD_LAT
// cycles after its grant.
//
// Parameters:
//   RD_LAT   (1..4)   memory read latency, address cycle to mem_rdata valid
//   MAX_LOCK (1..255) maximum consecutive locked grants for one owner
//
// Ports:
//   clk  system clock, rising edge
//   rst  synchronous active-high reset
//   bus  iomem_arbiter_if.slave: both master channels and the memory port
// ---------------------------------------------------------------------------
module iomem_arbiter #(
    parameter int RD_LAT   = 1,
    parameter int MAX_LOCK = 16
) (
    input  logic           clk,
    input  logic           rst,
    iomem_arbiter_if.slave bus
);

    typedef enum logic [1:0] {
        OWN_NONE = 2'd0,
        OWN_M0   = 2'd1,
        OWN_M1   = 2'd2
    } own_state_e;

    localparam logic [7:0] MAX_LOCK_CNT = 8'(MAX_LOCK);

    own_state_e        own_q, own_d;
    logic              last_q, last_d;
    logic [7:0]        lock_cnt_q, lock_cnt_d;
    logic              ready_q, ready_d;
    logic [RD_LAT-1:0] rd_valid_q, rd_valid_d;
    logic [RD_LAT-1:0] rd_id_q, rd_id_d;

    logic              issue_en;
    logic              req0;
    logic              req1;
    logic              gnt0;
    logic              gnt1;
    logic              gnt_any;
    logic              sel_we;
    logic              sel_lock;
    logic [7:0]        lock_cnt_inc;
    logic              out_valid;
    logic              rvalid0;
    logic              rvalid1;

    // Grant decision. Nothing is issued during reset or in the first cycle
    // after it (ready_q is still low). An owner excludes the other master
    // even while the owner itself is idle; otherwise a lone requester wins
    // and a tie goes to the master that was not granted last.
    always_comb begin
        gnt0     = 1'b0;
        gnt1     = 1'b0;
        issue_en = ready_q && !rst;
        req0     = bus.m0_req && issue_en;
        req1     = bus.m1_req && issue_en;
        case (own_q)
            OWN_M0: gnt0 = req0;
            OWN_M1: gnt1 = req1;
            default: begin
                if (req0 && req1) begin
                    gnt0 = last_q;
                    gnt1 = !last_q;
                end else begin
                    gnt0 = req0;
                    gnt1 = req1;
                end
            end
        endcase
    end

    // The winner's fields drive the memory port; with no grant the port is
    // held at zero so a write can never leak out.
    assign gnt_any       = gnt0 || gnt1;
    assign sel_we        = gnt1 ? bus.m1_we   : bus.m0_we;
    assign sel_lock      = gnt1 ? bus.m1_lock : bus.m0_lock;
    assign bus.m0_gnt    = gnt0;
    assign bus.m1_gnt    = gnt1;
    assign bus.mem_we    = gnt_any && sel_we;
    assign bus.mem_addr  = gnt1 ? bus.m1_addr  : (gnt0 ? bus.m0_addr  : 32'd0);
    assign bus.mem_wdata = gnt1 ? bus.m1_wdata : (gnt0 ? bus.m0_wdata : 32'd0);

    // Ownership, round-robin history and read-return tracking. A locked
    // grant extends ownership until the count reaches MAX_LOCK, at which
    // point ownership drops at that same edge and last_q hands the next tie
    // to the other master. An owner that neither requests nor holds lock
    // gives up ownership, but the waiting master only sees that next cycle.
    always_comb begin
        last_d       = last_q;
        own_d        = own_q;
        lock_cnt_d   = lock_cnt_q;
        ready_d      = 1'b1;
        rd_valid_d   = '0;
        rd_id_d      = '0;
        lock_cnt_inc = lock_cnt_q + 8'd1;

        if (gnt_any) begin
            last_d = gnt1;
            if (sel_lock && (lock_cnt_inc < MAX_LOCK_CNT)) begin
                own_d      = gnt1 ? OWN_M1 : OWN_M0;
                lock_cnt_d = lock_cnt_inc;
            end else begin
                own_d      = OWN_NONE;
                lock_cnt_d = 8'd0;
            end
        end else if (((own_q == OWN_M0) && !bus.m0_req && !bus.m0_lock) ||
                     ((own_q == OWN_M1) && !bus.m1_req && !bus.m1_lock)) begin
            own_d      = OWN_NONE;
            lock_cnt_d = 8'd0;
        end

        rd_valid_d[0] = gnt_any && !sel_we;
        rd_id_d[0]    = gnt1;
        for (int i = 1; i < RD_LAT; i++) begin
            rd_valid_d[i] = rd_valid_q[i-1];
            rd_id_d[i]    = rd_id_q[i-1];
        end
    end

    // State register. Reset discards any lock and all reads in flight, and
    // primes last_q so master 0 wins the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            last_q     <= 1'b1;
            own_q      <= OWN_NONE;
            lock_cnt_q <= 8'd0;
            ready_q    <= 1'b0;
            rd_valid_q <= '0;
            rd_id_q    <= '0;
        end else begin
            last_q     <= last_d;
            own_q      <= own_d;
            lock_cnt_q <= lock_cnt_d;
            ready_q    <= ready_d;
            rd_valid_q <= rd_valid_d;
            rd_id_q    <= rd_id_d;
        end
    end

    // Last pipeline stage lines up with mem_rdata; it is forced quiet while
    // reset is asserted so reads issued before reset never return.
    assign out_valid     = rd_valid_q[RD_LAT-1] && !rst;
    assign rvalid0       = out_valid && !rd_id_q[RD_LAT-1];
    assign rvalid1       = out_valid &&  rd_id_q[RD_LAT-1];
    assign bus.m0_rvalid = rvalid0;
    assign bus.m1_rvalid = rvalid1;
    assign bus.m0_rdata  = rvalid0 ? bus.mem_rdata : 32'd0;
    assign bus.m1_rdata  = rvalid1 ? bus.mem_rdata : 32'd0;

endmodule

// File: tb/tb_iomem_arbiter.sv
// ---------------------------------------------------------------------------
// tb_iomem_arbiter
// Testbench for iomem_arbiter with RD_LAT=2 and MAX_LOCK=4. A small memory
// model sits on the memory port. Each cycle is described by a vector of
// master inputs plus the expected grants; the expected memory-port values
// follow from the expected winner, and every expected read is queued with
// its due cycle and data, then matched against the rvalid/rdata outputs.
// ---------------------------------------------------------------------------
module tb_iomem_arbiter;

    localparam int RD_LAT   = 2;
    localparam int MAX_LOCK = 4;

    // {req, we, lock} encodings for one master in a vector
    localparam logic [2:0] IDLE = 3'b000;
    localparam logic [2:0] RD   = 3'b100;
    localparam logic [2:0] WR   = 3'b110;
    localparam logic [2:0] RDL  = 3'b101;
    localparam logic [2:0] WRL  = 3'b111;
    localparam logic [2:0] LK   = 3'b001;

    typedef struct {
        string       tag;
        logic        rst;
        logic [2:0]  op0;
        logic [31:0] a0;
        logic [31:0] d0;
        logic [2:0]  op1;
        logic [31:0] a1;
        logic [31:0] d1;
        logic        g0;
        logic        g1;
    } vec_t;

    typedef struct {
        logic        id;
        logic [31:0] data;
        int          due;
    } sb_entry_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_vec = 0;
    int   n_miss = 0;
    logic sb_enable = 1'b0;

    iomem_arbiter_if bus ();

    iomem_arbiter #(
        .RD_LAT   (RD_LAT),
        .MAX_LOCK (MAX_LOCK)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Power-on content of the memory model; 0x100 holds 0xDEADBEEF.
    function automatic logic [31:0] init_word(input logic [7:0] idx);
        if (idx == 8'h40) return 32'hDEADBEEF;
        return {16'hC0DE, 8'h00, idx};
    endfunction

    // Memory model: 256 words, RD_LAT-cycle read pipeline.
    logic [31:0] ram [256];
    logic [31:0] rd_pipe [RD_LAT];

    always @(posedge clk) begin
        if (cyc == 0) begin
            for (int i = 0; i < 256; i++) ram[i] <= init_word(8'(i));
        end else if (bus.mem_we) begin
            ram[bus.mem_addr[9:2]] <= bus.mem_wdata;
        end
        rd_pipe[0] <= ram[bus.mem_addr[9:2]];
        for (int i = 1; i < RD_LAT; i++) rd_pipe[i] <= rd_pipe[i-1];
    end

    assign bus.mem_rdata = rd_pipe[RD_LAT-1];

    // Expected memory content as seen by the bench.
    logic [31:0] model_mem [logic [31:0]];
    sb_entry_t   sb_q [$];
    vec_t        vecs [$];

    function automatic logic [31:0] expect_word(input logic [31:0] a);
        if (model_mem.exists(a)) return model_mem[a];
        return init_word(a[9:2]);
    endfunction

    function automatic vec_t mk(input string tag, input logic r,
                                input logic [2:0] op0, input logic [31:0] a0, input logic [31:0] d0,
                                input logic [2:0] op1, input logic [31:0] a1, input logic [31:0] d1,
                                input logic g0, input logic g1);
        vec_t v;
        v.tag = tag; v.rst = r;
        v.op0 = op0; v.a0 = a0; v.d0 = d0;
        v.op1 = op1; v.a1 = a1; v.d1 = d1;
        v.g0 = g0; v.g1 = g1;
        return v;
    endfunction

    task automatic check_val(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Compares grants and the memory port mid-cycle, then updates the
    // expected memory and queues any expected read return.
    task automatic check_output(input vec_t v);
        logic        ew;
        logic [31:0] ea;
        logic [31:0] ed;
        ew = 1'b0; ea = 32'd0; ed = 32'd0;
        if (v.g1) begin
            ew = v.op1[1]; ea = v.a1; ed = v.d1;
        end else if (v.g0) begin
            ew = v.op0[1]; ea = v.a0; ed = v.d0;
        end
        check_val({v.tag, ".gnt"}, 64'({bus.m0_gnt, bus.m1_gnt}), 64'({v.g0, v.g1}));
        check_val({v.tag, ".mem_we_addr"}, 64'({bus.mem_we, bus.mem_addr}), 64'({ew, ea}));
        check_val({v.tag, ".mem_wdata"}, 64'(bus.mem_wdata), 64'(ed));
        if (v.g0 || v.g1) begin
            if (ew) model_mem[ea] = ed;
            else    sb_q.push_back('{id: v.g1, data: expect_word(ea), due: cyc + RD_LAT});
        end
    endtask

    // Drives one cycle of master inputs just after the rising edge and
    // checks the combinational outputs on the falling edge.
    task automatic apply_stimulus(input vec_t v);
        rst           = v.rst;
        bus.m0_req    = v.op0[2]; bus.m0_we = v.op0[1]; bus.m0_lock = v.op0[0];
        bus.m0_addr   = v.a0;     bus.m0_wdata = v.d0;
        bus.m1_req    = v.op1[2]; bus.m1_we = v.op1[1]; bus.m1_lock = v.op1[0];
        bus.m1_addr   = v.a1;     bus.m1_wdata = v.d1;
        @(negedge clk);
        check_output(v);
        @(posedge clk);
        #1;
    endtask

    // Read-return scoreboard: each cycle either the oldest expected read is
    // due, or both rvalids must be low. Reset discards everything queued.
    always @(negedge clk) begin
        if (sb_enable) begin
            if (rst) begin
                sb_q.delete();
                check_val("rvalid_in_reset", 64'({bus.m0_rvalid, bus.m1_rvalid}), 64'd0);
            end else if (sb_q.size() > 0 && sb_q[0].due <= cyc) begin
                sb_entry_t e;
                e = sb_q.pop_front();
                check_val("rvalid_route", 64'({bus.m0_rvalid, bus.m1_rvalid}),
                          e.id ? 64'd1 : 64'd2);
                check_val("m0_rdata", 64'(bus.m0_rdata), e.id ? 64'd0 : 64'(e.data));
                check_val("m1_rdata", 64'(bus.m1_rdata), e.id ? 64'(e.data) : 64'd0);
            end else begin
                check_val("rvalid_idle", 64'({bus.m0_rvalid, bus.m1_rvalid}), 64'd0);
            end
        end
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        rst = 1'b1;
        bus.m0_req = 1'b0; bus.m0_we = 1'b0; bus.m0_lock = 1'b0; bus.m0_addr = '0; bus.m0_wdata = '0;
        bus.m1_req = 1'b0; bus.m1_we = 1'b0; bus.m1_lock = 1'b0; bus.m1_addr = '0; bus.m1_wdata = '0;
        @(posedge clk);
        #1;
        sb_enable = 1'b1;

        // Reset gating, first-cycle blocking, then round-robin contention.
        vecs.push_back(mk("rst0",  1, RD, 32'h100, 0, RD, 32'h104, 0, 0, 0));
        vecs.push_back(mk("rst1",  1, RD, 32'h100, 0, RD, 32'h104, 0, 0, 0));
        vecs.push_back(mk("post_rst", 0, RD, 32'h100, 0, RD, 32'h104, 0, 0, 0));
        for (int i = 0; i < 6; i++)
            vecs.push_back(mk("contend", 0, RD, 32'h100, 0, RD, 32'h104, 0, (i % 2) == 0, (i % 2) == 1));
        // Lone requesters win regardless of history.
        vecs.push_back(mk("single_m0", 0, RD,   32'h108, 0, IDLE, 0, 0, 1, 0));
        vecs.push_back(mk("idle0",     0, IDLE, 0,       0, IDLE, 0, 0, 0, 0));
        vecs.push_back(mk("single_m1", 0, IDLE, 0, 0, RD, 32'h10C, 0, 0, 1));
        vecs.push_back(mk("again_m1",  0, IDLE, 0, 0, RD, 32'h110, 0, 0, 1));
        vecs.push_back(mk("idle1",     0, IDLE, 0, 0, IDLE, 0, 0, 0, 0));
        // Write then read of the same VRAM word.
        vecs.push_back(mk("vram_wr", 0, IDLE, 0, 0, WR, 32'h2F0, 32'h55, 0, 1));
        vecs.push_back(mk("vram_rd", 0, RD, 32'h2F0, 0, IDLE, 0, 0, 1, 0));
        // m1 locks for three writes then an unlocked write; m0 starves.
        vecs.push_back(mk("lock_w0", 0, RD, 32'h100, 0, WRL, 32'h300, 32'hA1, 0, 1));
        vecs.push_back(mk("lock_w1", 0, RD, 32'h100, 0, WRL, 32'h304, 32'hA2, 0, 1));
        vecs.push_back(mk("lock_w2", 0, RD, 32'h100, 0, WRL, 32'h308, 32'hA3, 0, 1));
        vecs.push_back(mk("lock_w3", 0, RD, 32'h100, 0, WR,  32'h30C, 32'hA4, 0, 1));
        vecs.push_back(mk("lock_m0", 0, RD, 32'h100, 0, IDLE, 0, 0, 1, 0));
        vecs.push_back(mk("lock_rb", 0, RD, 32'h308, 0, IDLE, 0, 0, 1, 0));
        // Idle owner with lock blocks; dropping req+lock frees next cycle.
        vecs.push_back(mk("own_take", 0, RDL,  32'h100, 0, IDLE, 0, 0, 1, 0));
        vecs.push_back(mk("own_idle", 0, LK,   0,       0, RD, 32'h104, 0, 0, 0));
        vecs.push_back(mk("own_drop", 0, IDLE, 0,       0, RD, 32'h104, 0, 0, 0));
        vecs.push_back(mk("own_free", 0, IDLE, 0,       0, RD, 32'h104, 0, 0, 1));

        foreach (vecs[i]) apply_stimulus(vecs[i]);

        // Lock timeout: m0 holds lock+req forever, m1 keeps requesting.
        for (int k = 0; k < 15; k++)
            apply_stimulus(mk("lock_timeout", 0, RDL, 32'h100, 0, RD, 32'h104, 0,
                              (k % 5) != 4, (k % 5) == 4));

        // Reset with two reads in flight; first post-reset tie goes to m0.
        apply_stimulus(mk("mid_rd0",   0, RD, 32'h108, 0, IDLE, 0, 0, 1, 0));
        apply_stimulus(mk("mid_rd1",   0, RD, 32'h10C, 0, IDLE, 0, 0, 1, 0));
        apply_stimulus(mk("mid_rst",   1, RD, 32'h100, 0, RD, 32'h104, 0, 0, 0));
        apply_stimulus(mk("mid_post",  0, RD, 32'h100, 0, RD, 32'h104, 0, 0, 0));
        apply_stimulus(mk("mid_tie",   0, RD, 32'h100, 0, RD, 32'h104, 0, 1, 0));

        for (int i = 0; i < RD_LAT + 1; i++)
            apply_stimulus(mk("drain", 0, IDLE, 0, 0, IDLE, 0, 0, 0, 0));
        check_val("sb_drained", 64'(sb_q.size()), 64'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/iomem_arbiter.md
# iomem_arbiter

Shares the single data port of the I/O memory subsystem (RAM, VRAM, PS/2 keyboard window) between two bus masters: master 0 (ARM core data port) and master 1 (sprite/blitter engine). Single-beat transfers are arbitrated round-robin, one per cycle, with an optional lock for read-modify-write sequences. Read data is routed back to the issuing master after the memory's fixed read latency. The block sits between the masters and the I/O memory's `write_enable`/`address`/`data_input`/`data_output` port.

## Interface
- `RD_LAT`, 1: memory read latency in cycles, from address to `mem_rdata` valid; legal values are 1–4.
- `MAX_LOCK`, 16: maximum consecutive cycles a locked master keeps ownership; legal values are 1–255.

- `clk` input 1: single system clock; everything is on the rising edge.
- `rst` input 1: synchronous, active-high reset.
- `mN_req` input 1 (N=0,1): transfer request; address/data/we held stable while asserted.
- `mN_we` input 1: 1 = write, 0 = read.
- `mN_lock` input 1: request that ownership be retained after this transfer.
- `mN_addr` input 32: byte address.
- `mN_wdata` input 32: write data.
- `mN_gnt` output 1: transfer issued this cycle; request is consumed.
- `mN_rvalid` output 1: read data valid pulse.
- `mN_rdata` output 32: read data, valid when `mN_rvalid`=1.
- `mem_we` output 1: to memory write_enable.
- `mem_addr` output 32: to memory address.
- `mem_wdata` output 32: to memory data_input.
- `mem_rdata` input 32: from memory data_output.

## Operation
- Grant is decided combinationally each cycle from the current requests and the registered state; `mem_*` are muxed from the winner in the same cycle.
- When no master is granted: `mem_we`=0, `mem_addr`=0, `mem_wdata`=0. Writes must never be issued without a grant.
- Registered state:
  - `last` (1 bit): last granted master.
  - `owner_valid`, `owner` (1 bit each).
  - `lock_cnt` (8 bits).
  - Read-return shift register of depth `RD_LAT`, each entry {valid, id}.
- Arbitration:
  - If `owner_valid`, only `owner` may be granted; the other master waits even if the owner is idle.
  - Otherwise, if only one master requests, it wins. If both request, the master ≠ `last` wins.
- Lock:
  - A grant with `mN_lock`=1 sets `owner_valid`=1, `owner`=N, and increments `lock_cnt`.
  - A grant with `mN_lock`=0 clears `owner_valid` and `lock_cnt`.
  - When `lock_cnt` reaches `MAX_LOCK`, `owner_valid` clears at that edge regardless of lock; `last` makes the other master win next.
  - An owner dropping both req and lock for a cycle also releases ownership.
- Read return:
  - A granted read pushes {1, id} into the shift register. A write or no-grant pushes {0, x}.
  - At the output stage, `mN_rvalid` = valid && id==N, and `mN_rdata` = `mem_rdata`. `mN_rdata` is 0 when not valid.
- Reset: clears `last`→1 (so master 0 wins the first tie), `owner_valid`, `lock_cnt`, and all shift-register valids. No `rvalid` may appear from pre-reset reads.

## Timing
- Grant latency is 0 cycles: `mN_gnt` rises in the same cycle as `mN_req` if the master wins.
- Read data: `mN_rvalid` is asserted exactly `RD_LAT` cycles after the granting cycle.
- Back-to-back reads are supported: one issue per cycle, full throughput, in-order return.
- Masters must hold request fields until `gnt`. A deasserted req before gnt is a cancellation and has no effect.
- Outputs during reset cycle and first cycle after: all `gnt`/`rvalid`=0, `mem_we`=0.
- A reset asserted mid-lock or with reads in flight discards them at that edge.
- Simultaneous lock release by the owner and a request by the other master: the other master is granted in the next cycle (not the same cycle).

## Test plan
- Single read: m0 reads 0x100 (RAM preloaded with 0xDEADBEEF), `RD_LAT`=1 → `m0_gnt` at cycle 0; `m0_rvalid`=1 with `m0_rdata`=0xDEADBEEF at cycle 1; m1 sees no rvalid.
- Contention: both request reads continuously for 6 cycles after reset → grants alternate m0,m1,m0,m1,m0,m1; rdata returns to the matching master in order.
- Lock: m1 issues 3 locked writes then an unlocked write while m0 requests throughout → m0 is starved for 4 cycles, then granted on cycle 4.
- Lock timeout: `MAX_LOCK`=4, m0 holds lock+req indefinitely with m1 requesting → m0 gets 4 grants, m1 gets 1, and the pattern repeats.
- Reset mid-flight: `RD_LAT`=3, m0 issues 2 reads, `rst` asserted 1 cycle later → no `m0_rvalid` is ever produced; the first post-reset tie is granted to m0.
- Write/read mix: m1 writes 0x55 to a VRAM address, m0 reads the same address the next cycle → `mem_we`=1 only in the m1 grant cycle; m0 receives 0x55.
